// File: rtl/topk_insert_pkg.sv
// Shared word layout for the margin-sampling datapath: {addr, indx, data} packing,
// field offsets and extract helpers used by the top-K collector and the max tree wrapper.
package topk_insert_pkg;

  localparam int DATA_W   = 16;
  localparam int INDX_W   = 10;
  localparam int ADDR_W   = 7;
  localparam int WORD_W   = DATA_W + INDX_W + ADDR_W;

  localparam int DATA_LSB = 0;
  localparam int INDX_LSB = DATA_W;
  localparam int ADDR_LSB = DATA_W + INDX_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [INDX_W-1:0] indx_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Per-slot next-state selection.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_SHIFT = 2'd1,
    SLOT_LOAD  = 2'd2
  } slot_op_e;

  function automatic data_t word_data(input word_t w);
    return w[DATA_LSB +: DATA_W];
  endfunction

  function automatic indx_t word_indx(input word_t w);
    return w[INDX_LSB +: INDX_W];
  endfunction

  function automatic addr_t word_addr(input word_t w);
    return w[ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/topk_insert_slot.sv
// One entry of the sorted top-K list: holds a word and its occupied flag, and either
// keeps it, takes the upper neighbour's entry (shift down) or captures the candidate.
module topk_slot
  import topk_insert_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_en_i,
  input  logic         gt_i,
  input  logic         gt_up_i,
  input  logic [W-1:0] word_up_i,
  input  logic         vld_up_i,
  input  logic [W-1:0] cand_i,
  output logic [W-1:0] word_o,
  output logic         vld_o
);

  slot_op_e     op;
  logic [W-1:0] word_q, word_d;
  logic         vld_q, vld_d;

  // The list is sorted, so an upper slot beaten by the candidate implies this one is too;
  // only the first beaten slot loads, everything below it shifts.
  always_comb begin
    op = SLOT_HOLD;
    if (load_en_i && gt_up_i) begin
      op = SLOT_SHIFT;
    end else if (load_en_i && gt_i) begin
      op = SLOT_LOAD;
    end
  end

  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    if (clear_i) begin
      word_d = '0;
      vld_d  = 1'b0;
    end else begin
      case (op)
        SLOT_SHIFT: begin
          word_d = word_up_i;
          vld_d  = vld_up_i;
        end
        SLOT_LOAD: begin
          word_d = cand_i;
          vld_d  = 1'b1;
        end
        default: begin
          word_d = word_q;
          vld_d  = vld_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o = word_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/topk_insert.sv
// Sorted top-K collector: keeps the TOPK largest-DATA tree winners in descending order
// (slot 0 = largest, earlier arrival wins ties) and flags done after NUM_CAND accepts.
module topk_insert
  import topk_insert_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int INDX_WIDTH = INDX_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int TOPK       = 8,
  parameter int NUM_CAND   = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                clear,
  input  logic                                                cand_valid,
  input  logic [DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH-1:0]         cand,
  output logic [TOPK*(DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH)-1:0]  topk_flat,
  output logic [TOPK-1:0]                                     topk_vld,
  output logic [7:0]                                          cand_cnt,
  output logic                                                done
);

  localparam int SLOT_W = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH;

  logic              accept;
  logic [SLOT_W-1:0] word_s [TOPK];
  logic [TOPK-1:0]   vld_s;
  logic [TOPK-1:0]   gt_s;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  assign accept = cand_valid && !done_q && !clear;

  for (genvar gi = 0; gi < TOPK; gi++) begin : g_slot
    // An empty slot ranks below every value, including 0; ties keep the resident entry.
    assign gt_s[gi] = !vld_s[gi] || (cand[DATA_WIDTH-1:0] > word_s[gi][DATA_WIDTH-1:0]);

    if (gi == 0) begin : g_head
      topk_slot #(.W(SLOT_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .load_en_i (accept),
        .gt_i      (gt_s[gi]),
        .gt_up_i   (1'b0),
        .word_up_i ({SLOT_W{1'b0}}),
        .vld_up_i  (1'b0),
        .cand_i    (cand),
        .word_o    (word_s[gi]),
        .vld_o     (vld_s[gi])
      );
    end else begin : g_body
      topk_slot #(.W(SLOT_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .load_en_i (accept),
        .gt_i      (gt_s[gi]),
        .gt_up_i   (gt_s[gi-1]),
        .word_up_i (word_s[gi-1]),
        .vld_up_i  (vld_s[gi-1]),
        .cand_i    (cand),
        .word_o    (word_s[gi]),
        .vld_o     (vld_s[gi])
      );
    end

    assign topk_flat[gi*SLOT_W +: SLOT_W] = word_s[gi];
  end

  assign topk_vld = vld_s;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (accept) begin
      cnt_d  = cnt_q + 8'd1;
      done_d = (cnt_q == 8'(NUM_CAND - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cand_cnt = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_topk_insert.sv
// Bench for topk_insert: TOPK=8 and TOPK=4 instances share one stimulus stream; a queue
// of expected snapshots is checked by a separate monitor, plus hand-computed final lists.
module tb_topk_insert;

  localparam int W = 33;

  logic                clk;
  logic                rst;
  logic                clear;
  logic                cand_valid;
  logic [W-1:0]        cand;
  logic [8*W-1:0]      flat8;
  logic [7:0]          vld8;
  logic [7:0]          cnt8;
  logic                done8;
  logic [4*W-1:0]      flat4;
  logic [3:0]          vld4;
  logic [7:0]          cnt4;
  logic                done4;

  topk_insert #(.TOPK(8), .NUM_CAND(8)) u_dut8 (
    .clk(clk), .rst(rst), .clear(clear), .cand_valid(cand_valid), .cand(cand),
    .topk_flat(flat8), .topk_vld(vld8), .cand_cnt(cnt8), .done(done8)
  );

  topk_insert #(.TOPK(4), .NUM_CAND(8)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .cand_valid(cand_valid), .cand(cand),
    .topk_flat(flat4), .topk_vld(vld4), .cand_cnt(cnt4), .done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int             due;
    string          tag;
    logic [8*W-1:0] flat8;
    logic [7:0]     vld8;
    logic [4*W-1:0] flat4;
    logic [3:0]     vld4;
    logic [7:0]     cnt;
    logic           done;
  } exp_t;

  exp_t         sb[$];
  int           cyc;
  int           nvec;
  int           nerr;
  logic [W-1:0] m  [2][8];
  logic [7:0]   mv [2];
  int           mcnt;
  logic         mdone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int d, input int idx, input int addr);
    logic [15:0] dd;
    logic [9:0]  ii;
    logic [6:0]  aa;
    dd = d[15:0];
    ii = idx[9:0];
    aa = addr[6:0];
    return {aa, ii, dd};
  endfunction

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++) begin
      mv[d] = '0;
      for (int i = 0; i < 8; i++) m[d][i] = '0;
    end
    mcnt  = 0;
    mdone = 1'b0;
  endtask

  task automatic mdl_ins(input int d, input int k, input logic [W-1:0] c);
    int pos = -1;
    for (int i = 0; i < k; i++)
      if (pos < 0 && (!mv[d][i] || c[15:0] > m[d][i][15:0])) pos = i;
    if (pos >= 0) begin
      for (int j = k - 1; j > pos; j--) begin
        m[d][j]  = m[d][j-1];
        mv[d][j] = mv[d][j-1];
      end
      m[d][pos]  = c;
      mv[d][pos] = 1'b1;
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.due   = cyc + 1;
    e.tag   = tag;
    e.flat8 = '0;
    e.flat4 = '0;
    for (int k = 0; k < 8; k++) e.flat8[k*W +: W] = m[0][k];
    for (int k = 0; k < 4; k++) e.flat4[k*W +: W] = m[1][k];
    e.vld8  = mv[0];
    e.vld4  = mv[1][3:0];
    e.cnt   = 8'(mcnt);
    e.done  = mdone;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [W-1:0] c, input logic clr, input string tag);
    @(negedge clk);
    cand_valid = v;
    cand       = c;
    clear      = clr;
    if (clr) begin
      mdl_clear();
    end else if (v && !mdone) begin
      mdl_ins(0, 8, c);
      mdl_ins(1, 4, c);
      mcnt++;
      if (mcnt == 8) mdone = 1'b1;
    end
    push(tag);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, "idle");
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".flat8"}, flat8, e.flat8);
      chk({e.tag, ".vld8"},  vld8,  e.vld8);
      chk({e.tag, ".cnt8"},  cnt8,  e.cnt);
      chk({e.tag, ".done8"}, done8, e.done);
      chk({e.tag, ".flat4"}, flat4, e.flat4);
      chk({e.tag, ".vld4"},  vld4,  e.vld4);
      chk({e.tag, ".cnt4"},  cnt4,  e.cnt);
      chk({e.tag, ".done4"}, done4, e.done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1[8]   = '{5, 9, 1, 9, 7, 3, 2, 8};
    int e1[8]   = '{9, 9, 8, 7, 5, 3, 2, 1};
    int d2[8]   = '{100, 50, 200, 50, 0, 300, 7, 150};
    int e2[8]   = '{300, 200, 150, 100, 50, 50, 7, 0};
    cyc = 0; nvec = 0; nerr = 0;
    rst = 1'b1; clear = 1'b0; cand_valid = 1'b0; cand = '0;
    mdl_clear();
    repeat (2) @(negedge clk);
    chk("reset.flat8", flat8, '0);
    chk("reset.vld8",  vld8,  '0);
    chk("reset.cnt8",  cnt8,  '0);
    chk("reset.done8", done8, '0);
    rst = 1'b0;

    // Mixed order with a tie on 9: earlier arrival keeps the higher rank.
    for (int i = 0; i < 8; i++) step(1'b1, mk(d1[i], i + 1, i), 1'b0, "sort8");
    idle();
    drain();
    for (int k = 0; k < 8; k++) chk($sformatf("sort8.slot%0d", k), flat8[k*W +: 16], 16'(e1[k]));
    chk("sort8.tie_first_idx",  flat8[0*W+16 +: 10], 10'd2);
    chk("sort8.tie_second_idx", flat8[1*W+16 +: 10], 10'd4);
    chk("sort8.vld",  vld8,  8'hFF);
    chk("sort8.done", done8, 1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("sort4.slot%0d", k), flat4[k*W +: 16], 16'(e1[k]));

    // Valid held high after done: nothing may change.
    for (int i = 0; i < 3; i++) step(1'b1, mk(16'hFFFF, 900 + i, 1), 1'b0, "after_done");
    idle();
    drain();
    chk("after_done.cnt",   cnt8, 8'd8);
    chk("after_done.slot0", flat8[0 +: 16], 16'd9);

    // clear wins over a simultaneous maximal candidate.
    step(1'b1, mk(16'hFFFF, 77, 3), 1'b1, "clear_win");
    idle();
    drain();
    chk("clear_win.flat", flat8, '0);
    chk("clear_win.vld",  vld8,  '0);
    chk("clear_win.cnt",  cnt8,  '0);
    chk("clear_win.done", done8, '0);

    // Ascending: each new value lands in slot 0.
    for (int i = 1; i <= 8; i++) step(1'b1, mk(i, 10 + i, i), 1'b0, "ascend");
    idle();
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("ascend4.slot%0d", k), flat4[k*W +: 16], 16'(8 - k));
    chk("ascend4.vld", vld4, 4'hF);

    // Zero-valued candidates still fill empty slots from the LSB.
    step(1'b0, '0, 1'b1, "clear_z");
    for (int i = 0; i < 3; i++) step(1'b1, mk(0, 200 + i, i), 1'b0, "zeros");
    idle();
    drain();
    chk("zeros.vld8", vld8, 8'h07);
    chk("zeros.slot0_idx", flat8[16 +: 10], 10'd200);
    chk("zeros.slot2_idx", flat8[2*W+16 +: 10], 10'd202);

    // Asynchronous reset mid-cycle after a partial selection.
    step(1'b0, '0, 1'b1, "clear_r");
    for (int i = 0; i < 3; i++) step(1'b1, mk(10 * (i + 1), 300 + i, i), 1'b0, "pre_rst");
    idle();
    drain();
    @(posedge clk);
    #2;
    rst = 1'b1;
    mdl_clear();
    #1;
    chk("async_rst.flat8", flat8, '0);
    chk("async_rst.vld8",  vld8,  '0);
    chk("async_rst.cnt8",  cnt8,  '0);
    chk("async_rst.flat4", flat4, '0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, mk(d2[i], 400 + i, i), 1'b0, "post_rst");
    idle();
    drain();
    for (int k = 0; k < 8; k++) chk($sformatf("post_rst.slot%0d", k), flat8[k*W +: 16], 16'(e2[k]));
    chk("post_rst.done", done8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/topk_insert.md
# topk_insert

Sorted top-K collector downstream of the 128-input max tree in the margin-sampling datapath. Each tree pass produces one packed {addr, index, data} winner. This block accepts those winners one per cycle and keeps the K entries with the largest DATA field in a descending-sorted register list. After a programmed number of candidates it flags completion, so the controller can read the K best samples of the 1024-sample batch.

## Interface
- DATA_WIDTH, 16, score field width; occupies bits [DATA_WIDTH-1:0] of a word
- INDX_WIDTH, 10, sample index field, directly above DATA
- ADDR_WIDTH, 7, memory address field, top bits of the word
- TOPK, 8, number of retained entries (2..16)
- NUM_CAND, 8, candidates per selection (1..255)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  sync pulse; empties list, restarts candidate count
- cand_valid  input  1  cand holds a tree winner this cycle
- cand  input  DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH  packed candidate {addr, indx, data}
- topk_flat  output  TOPK*(DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH)  slot 0 in LSBs, slot 0 = largest
- topk_vld  output  TOPK  per-slot occupied flag, bit i for slot i
- cand_cnt  output  8  candidates accepted since last clear
- done  output  1  high once cand_cnt == NUM_CAND, held until clear/rst

## Operation
- Reset: all slots 0, topk_vld 0, cand_cnt 0, done 0.
- Accept condition: cand_valid && !done && !clear. Otherwise cand is ignored.
- Comparison key is DATA only, unsigned. An empty slot ranks below any value, including 0.
- Insertion: find the lowest slot i where the slot is empty or cand.data > slot[i].data (strict).
  - Slots i..TOPK-2 shift down one position; the old slot TOPK-1 is discarded.
  - cand is written to slot i and topk_vld[i] is set.
  - If no such slot exists, the list is unchanged.
- Ties: the earlier arrival keeps the higher rank.
- cand_cnt increments on every accepted candidate, whether or not it was inserted.
- done is set on the same edge that makes cand_cnt reach NUM_CAND.
- clear has priority over cand_valid in the same cycle:
  - slots, topk_vld, cand_cnt and done all go to 0;
  - the candidate in that cycle is dropped.
- Reset mid-selection: immediate return to reset values; no partial state survives.
- No backpressure. The block accepts one candidate every cycle.

## Timing
- Registered outputs only. An insertion is visible on topk_flat/topk_vld the cycle after the accepting edge.
- Latency: 1 cycle from cand_valid to list update. done is high the cycle after the NUM_CAND-th accept.
- Back-to-back candidates on consecutive cycles are fully supported.
- Critical path: TOPK parallel DATA comparators, then priority select, then per-slot mux.

## Structure
- Shared package holds:
  - WORD_W = DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH;
  - field offset constants DATA_LSB, INDX_LSB, ADDR_LSB;
  - data/indx/addr field-extract functions, also reused by the max tree wrapper.
- Sub-module topk_slot: one register slot holding a word and its valid bit.
  - Inputs: own compare result, upper neighbour's compare result, upper neighbour's word, cand, load enable, clear.
  - Next-state: hold, shift from upper neighbour, or load cand.
- Top level: TOPK topk_slot instances, candidate counter, done flag.

## Test plan
- Reset, then NUM_CAND=8 candidates with data 5,9,1,9,7,3,2,8 and distinct indices → sorted order 9(first),9(second),8,7,5,3,2,1; topk_vld=8'hFF; done=1 one cycle after the 8th accept.
- TOPK=4, candidates data 1..8 ascending → final slots 8,7,6,5; each cycle the new value lands in slot 0.
- Candidates with data 0 into an empty list → inserted (valid bit wins); topk_vld fills from LSB.
- cand_valid held high after done → list and cand_cnt unchanged.
- clear asserted together with cand_valid (data 0xFFFF) → list empty, cand_cnt=0, done=0, candidate absent.
- rst asserted asynchronously after 3 candidates, mid-cycle → outputs zero immediately, without waiting for a clock edge. After release, 8 new candidates produce a correct list and done.
